// File: rtl/dac_spi_tx.sv
// Dual-channel SPI DAC transmitter: shifts an (x, y) sample pair out as two
// 16-bit command words (channel A then B) and strobes LDAC to update both outputs.
module dac_spi_tx #(
    parameter int OUT_WIDTH = 12,
    parameter int SCLK_DIV  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OUT_WIDTH-1:0] x_in,
    input  logic [OUT_WIDTH-1:0] y_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs_n,
    output logic                 ldac_n,
    output logic                 busy
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_X,
        GAP_X,
        SHIFT_Y,
        GAP_Y,
        LDAC
    } state_t;

    state_t               state_reg, state_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic                 phase_reg, phase_next;
    logic [3:0]           bit_reg, bit_next;
    logic [15:0]          word_reg, word_next;
    logic [OUT_WIDTH-1:0] y_reg, y_next;
    logic                 div_last;
    logic                 shifting;

    // Command word: channel select, unbuffered, gain 1x, active, left-justified sample.
    function automatic logic [15:0] make_word(input logic ch, input logic [OUT_WIDTH-1:0] s);
        logic [11:0] field;
        field = 12'(s) << (12 - OUT_WIDTH);
        return {ch, 3'b011, field};
    endfunction

    assign div_last = (div_reg == DIV_LAST);
    assign shifting = (state_reg == SHIFT_X) || (state_reg == SHIFT_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            phase_reg <= 1'b0;
            bit_reg   <= 4'd15;
            word_reg  <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            phase_reg <= phase_next;
            bit_reg   <= bit_next;
            word_reg  <= word_next;
            y_reg     <= y_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_next   = div_last ? '0 : div_reg + 1'b1;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        word_next  = word_reg;
        y_next     = y_reg;
        case (state_reg)
            IDLE: begin
                div_next = '0;
                if (valid) begin
                    state_next = SHIFT_X;
                    word_next  = make_word(1'b0, x_in);
                    y_next     = y_in;
                    phase_next = 1'b0;
                    bit_next   = 4'd15;
                end
            end
            SHIFT_X, SHIFT_Y: begin
                if (div_last) begin
                    if (!phase_reg) begin
                        phase_next = 1'b1;
                    end else begin
                        // Falling sclk: advance to the next bit, or finish the word.
                        phase_next = 1'b0;
                        if (bit_reg == 4'd0) begin
                            state_next = (state_reg == SHIFT_X) ? GAP_X : GAP_Y;
                        end else begin
                            bit_next  = bit_reg - 1'b1;
                            word_next = {word_reg[14:0], 1'b0};
                        end
                    end
                end
            end
            GAP_X: begin
                if (div_last) begin
                    state_next = SHIFT_Y;
                    word_next  = make_word(1'b1, y_reg);
                    bit_next   = 4'd15;
                    phase_next = 1'b0;
                end
            end
            GAP_Y: begin
                if (div_last) state_next = LDAC;
            end
            LDAC: begin
                if (div_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready  = (state_reg == IDLE);
    assign busy   = !ready;
    assign cs_n   = !shifting;
    assign sclk   = shifting && phase_reg;
    assign mosi   = shifting && word_reg[15];
    assign ldac_n = (state_reg != LDAC);

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (D=4/W=12, D=4/W=8, D=1/W=12); a monitor
// deserialises MOSI at each sclk rise, and tasks compare against a queue of expected words.
module tb_dac_spi_tx;

    logic        clk;
    logic        rst;
    logic [11:0] x_s [3];
    logic [11:0] y_s [3];
    logic [2:0]  valid_s;
    logic [2:0]  ready_w, busy_w, sclk_w, mosi_w, cs_n_w, ldac_n_w;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q [$];
    int rd_idx [3];

    // Monitor state
    logic [15:0] sh [3];
    int          nb [3];
    logic [2:0]  sprev;
    logic [15:0] cap_mem [3][32];
    int          cap_cnt [3];

    dac_spi_tx #(.OUT_WIDTH(12), .SCLK_DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .x_in(x_s[0]), .y_in(y_s[0]), .valid(valid_s[0]),
        .ready(ready_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .cs_n(cs_n_w[0]),
        .ldac_n(ldac_n_w[0]), .busy(busy_w[0]));

    dac_spi_tx #(.OUT_WIDTH(8), .SCLK_DIV(4)) u_w8 (
        .clk(clk), .rst(rst), .x_in(x_s[1][7:0]), .y_in(y_s[1][7:0]), .valid(valid_s[1]),
        .ready(ready_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .cs_n(cs_n_w[1]),
        .ldac_n(ldac_n_w[1]), .busy(busy_w[1]));

    dac_spi_tx #(.OUT_WIDTH(12), .SCLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .x_in(x_s[2]), .y_in(y_s[2]), .valid(valid_s[2]),
        .ready(ready_w[2]), .sclk(sclk_w[2]), .mosi(mosi_w[2]), .cs_n(cs_n_w[2]),
        .ldac_n(ldac_n_w[2]), .busy(busy_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture one bit per sclk rise; a reset discards any partial word.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                nb[i]      <= 0;
                sh[i]      <= '0;
                sprev[i]   <= 1'b0;
                cap_cnt[i] <= 0;
            end else begin
                sprev[i] <= sclk_w[i];
                if (sclk_w[i] && !sprev[i]) begin
                    if (nb[i] == 15) begin
                        if (cap_cnt[i] < 32) cap_mem[i][cap_cnt[i]] <= {sh[i][14:0], mosi_w[i]};
                        cap_cnt[i] <= cap_cnt[i] + 1;
                        nb[i]      <= 0;
                    end else begin
                        sh[i] <= {sh[i][14:0], mosi_w[i]};
                        nb[i] <= nb[i] + 1;
                    end
                end
            end
        end
    end

    function automatic logic [15:0] cmd(input logic ch, input logic [11:0] s, input int w);
        logic [11:0] f;
        f = s << (12 - w);
        return {ch, 3'b011, f};
    endfunction

    // Handshake on the next edge, then drop valid.
    task automatic start(input int i, input logic [11:0] x, input logic [11:0] y);
        x_s[i] = x;
        y_s[i] = y;
        valid_s[i] = 1'b1;
        @(posedge clk); #1;
        valid_s[i] = 1'b0;
    endtask

    // Observe one transfer from the cycle after its handshake until ready returns.
    task automatic measure(input int i, output int cycles, output int cs_low,
                           output int ldac_low, output int rises, output int bad);
        logic prev_sclk, prev_mosi;
        prev_sclk = 1'b0; prev_mosi = 1'b0;
        cycles = 0; cs_low = 0; ldac_low = 0; rises = 0; bad = 0;
        do begin
            if (!cs_n_w[i]) cs_low++;
            if (!ldac_n_w[i]) ldac_low++;
            if (sclk_w[i] && !prev_sclk) rises++;
            if (cs_n_w[i] && (sclk_w[i] || mosi_w[i])) bad++;
            if (busy_w[i] === ready_w[i]) bad++;
            if (sclk_w[i] && prev_sclk && (mosi_w[i] !== prev_mosi)) bad++;
            prev_sclk = sclk_w[i];
            prev_mosi = mosi_w[i];
            @(posedge clk); #1;
            cycles++;
        end while (ready_w[i] !== 1'b1 && cycles < 2000);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        valid_s = '0;
        for (int i = 0; i < 3; i++) begin
            x_s[i] = '0; y_s[i] = '0; rd_idx[i] = 0;
        end
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({ready_w[i], busy_w[i], cs_n_w[i], sclk_w[i], mosi_w[i], ldac_n_w[i]} !== 6'b101001) begin
                n_err++;
                $display("FAIL reset_values inst%0d: rdy/busy/cs_n/sclk/mosi/ldac_n=%b%b%b%b%b%b want 101001",
                         i, ready_w[i], busy_w[i], cs_n_w[i], sclk_w[i], mosi_w[i], ldac_n_w[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single(input int i, input logic [11:0] x, input logic [11:0] y,
                               input logic [15:0] wa, input logic [15:0] wb, input int d);
        int cyc, csl, ldl, ris, bad;
        logic [15:0] e;
        exp_q.push_back(wa);
        exp_q.push_back(wb);
        start(i, x, y);
        n_vec++;
        if ({ready_w[i], cs_n_w[i], sclk_w[i], mosi_w[i]} !== 4'b0000) begin
            n_err++;
            $display("FAIL first_cycle inst%0d: rdy/cs_n/sclk/mosi=%b%b%b%b want 0000",
                     i, ready_w[i], cs_n_w[i], sclk_w[i], mosi_w[i]);
        end
        measure(i, cyc, csl, ldl, ris, bad);
        n_vec++;
        if (cyc != 67 * d) begin
            n_err++; $display("FAIL xfer_cycles inst%0d: got %0d want %0d", i, cyc, 67 * d);
        end
        n_vec++;
        if (csl != 64 * d) begin
            n_err++; $display("FAIL cs_low_cycles inst%0d: got %0d want %0d", i, csl, 64 * d);
        end
        n_vec++;
        if (ldl != d) begin
            n_err++; $display("FAIL ldac_low_cycles inst%0d: got %0d want %0d", i, ldl, d);
        end
        n_vec++;
        if (ris != 32 || bad != 0) begin
            n_err++; $display("FAIL sclk_protocol inst%0d: rises %0d want 32, violations %0d want 0", i, ris, bad);
        end
        repeat (2) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rd_idx[i] >= cap_cnt[i]) begin
                n_err++; $display("FAIL word inst%0d: none captured want %h", i, e);
            end else begin
                if (cap_mem[i][rd_idx[i]] !== e) begin
                    n_err++; $display("FAIL word inst%0d: got %h want %h", i, cap_mem[i][rd_idx[i]], e);
                end
                rd_idx[i]++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc, csl, ldl, ris, bad;
        logic [15:0] e;
        exp_q.push_back(16'h3000);
        exp_q.push_back(16'hBFFF);
        exp_q.push_back(16'h3FFF);
        exp_q.push_back(16'hB000);
        x_s[0] = 12'h000; y_s[0] = 12'hFFF; valid_s[0] = 1'b1;
        @(posedge clk); #1;
        x_s[0] = 12'h5A5; y_s[0] = 12'hA5A;  // must be ignored while busy
        measure(0, cyc, csl, ldl, ris, bad);
        n_vec++;
        if (cyc != 268 || bad != 0) begin
            n_err++; $display("FAIL b2b_first inst0: cycles %0d want 268, violations %0d want 0", cyc, bad);
        end
        x_s[0] = 12'hFFF; y_s[0] = 12'h000;
        @(posedge clk); #1;
        n_vec++;
        if ({ready_w[0], cs_n_w[0]} !== 2'b00) begin
            n_err++; $display("FAIL b2b_ready_pulse inst0: rdy/cs_n=%b%b want 00", ready_w[0], cs_n_w[0]);
        end
        valid_s[0] = 1'b0;
        measure(0, cyc, csl, ldl, ris, bad);
        n_vec++;
        if (cyc != 268 || ldl != 4) begin
            n_err++; $display("FAIL b2b_second inst0: cycles %0d want 268, ldac %0d want 4", cyc, ldl);
        end
        repeat (4) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rd_idx[0] >= cap_cnt[0]) begin
                n_err++; $display("FAIL b2b_word inst0: none captured want %h", e);
            end else begin
                if (cap_mem[0][rd_idx[0]] !== e) begin
                    n_err++; $display("FAIL b2b_word inst0: got %h want %h", cap_mem[0][rd_idx[0]], e);
                end
                rd_idx[0]++;
            end
        end
    endtask

    task automatic test_abort;
        int ldl, rdy_low;
        logic [15:0] e;
        exp_q.push_back(16'h3321);
        start(0, 12'h321, 12'h654);
        // Bit 5 of word B covers edges k+212..k+219 at D=4; we now sit after edge k.
        repeat (214) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if ({cs_n_w[0], sclk_w[0], mosi_w[0], ready_w[0], ldac_n_w[0]} !== 5'b10011) begin
            n_err++;
            $display("FAIL abort_immediate inst0: cs_n/sclk/mosi/rdy/ldac_n=%b%b%b%b%b want 10011",
                     cs_n_w[0], sclk_w[0], mosi_w[0], ready_w[0], ldac_n_w[0]);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (rd_idx[0] >= cap_cnt[0] || cap_mem[0][rd_idx[0]] !== e) begin
            n_err++; $display("FAIL abort_word_a inst0: got %h (count %0d) want %h",
                              cap_mem[0][rd_idx[0]], cap_cnt[0], e);
        end
        @(negedge clk);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) rd_idx[i] = 0;
        @(posedge clk); #1;
        ldl = 0; rdy_low = 0;
        repeat (300) begin
            if (!ldac_n_w[0]) ldl++;
            if (!ready_w[0] || !cs_n_w[0]) rdy_low++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (ldl != 0 || rdy_low != 0 || cap_cnt[0] != 0) begin
            n_err++; $display("FAIL abort_quiet inst0: ldac_low %0d, busy %0d, words %0d want all 0",
                              ldl, rdy_low, cap_cnt[0]);
        end
        test_single(0, 12'h0F0, 12'h70F, cmd(1'b0, 12'h0F0, 12), cmd(1'b1, 12'h70F, 12), 4);
    endtask

    initial begin
        test_reset();
        test_single(0, 12'hABC, 12'h123, 16'h3ABC, 16'hB123, 4);
        test_single(1, 12'h0FF, 12'h001, 16'h3FF0, 16'hB010, 4);
        test_back_to_back();
        test_abort();
        test_single(2, 12'h555, 12'hAAA, 16'h3555, 16'hBAAA, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial transmitter that accepts one (x, y) vector sample pair per handshake and shifts it to a dual-channel 12-bit SPI DAC as two 16-bit command words, channel A = x and channel B = y. After both words it pulses LDAC so both outputs update simultaneously. It sits downstream of the vector display drawing logic, converting its parallel x/y channel words into the DAC's serial pins.

## Interface
Parameters:
- OUT_WIDTH, 12: width of x_in/y_in (legal 8..12); left-justified into the 12-bit DAC field, LSBs zero-filled.
- SCLK_DIV, 4: clk cycles per SCLK half-period (D, legal >= 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- x_in  input  OUT_WIDTH  x sample, channel A.
- y_in  input  OUT_WIDTH  y sample, channel B.
- valid  input  1  sample pair present.
- ready  output  1  high only in IDLE; a transfer is accepted on a clk edge where valid && ready.
- sclk  output  1  SPI clock, mode 0 (idle low; DAC samples on rising edge).
- mosi  output  1  serial data, MSB first.
- cs_n  output  1  chip select, active low.
- ldac_n  output  1  latch strobe, active low.
- busy  output  1  equals !ready.

## Operation
- Command word: [15] channel (0 = A/x, 1 = B/y), [14] 0 (unbuffered), [13] 1 (gain 1x), [12] 1 (active), [11:0] sample << (12-OUT_WIDTH).
- On handshake, both samples are registered. Later changes on x_in/y_in or valid have no effect until the next IDLE.
- FSM states and transitions:
  - IDLE: leaves on handshake, goes to SHIFT_X.
  - SHIFT_X: 16 bits, 2D cycles each; then GAP_X.
  - GAP_X: D cycles; then SHIFT_Y.
  - SHIFT_Y: 16 bits; then GAP_Y.
  - GAP_Y: D cycles; then LDAC.
  - LDAC: D cycles; then IDLE.
- Per bit in SHIFT states:
  - The first D cycles have sclk = 0, with mosi holding the bit value from the bit's first cycle.
  - The next D cycles have sclk = 1.
  - mosi changes only while sclk is low, on the cycle sclk falls or at word start.
- cs_n is low exactly during SHIFT_X and SHIFT_Y. It is high in GAP, LDAC and IDLE.
- sclk is low whenever cs_n is high.
- ldac_n is low exactly during LDAC.
- In the GAP, LDAC and IDLE states, mosi = 0.
- Counters:
  - The divider counts 0..D-1.
  - The 4-bit bit counter counts 15 down to 0.
  - The word register is a 16-bit shift register, shifted left at each sclk falling transition.
- Reset mid-transfer aborts immediately:
  - The FSM returns to IDLE.
  - The sample registers are cleared.
  - No LDAC pulse is issued.
  - The DAC sees cs_n rise, which makes the partial word ignored.

## Timing
- Reset values: ready = 1, busy = 0, cs_n = 1, sclk = 0, mosi = 0, ldac_n = 1.
- For a handshake at edge k:
  - From edge k: cs_n = 0, sclk = 0, mosi = bit 15 of word A (= 0).
  - Word A occupies 32D cycles.
  - GAP_X and GAP_Y are D cycles each.
  - Word B occupies 32D cycles.
  - ldac_n is low from edge k+66D to k+67D.
  - ready returns high at edge k+67D.
- Throughput: 67D cycles per pair; 268 cycles at D = 4.
- Back-to-back:
  - If valid is held high, the next pair is accepted on the first IDLE edge.
  - The new cs_n falls one cycle after ready rises; ready is high for exactly one cycle.
- valid without ready is ignored; there is no queuing.
- sclk rising edges occur D cycles after each mosi update, giving D cycles of setup and D cycles of hold.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> outputs take reset values immediately; ready = 1.
- Single transfer, D = 4, OUT_WIDTH = 12, x = 0xABC, y = 0x123 -> captured MOSI at sclk rises:
  - Word A: 0x3ABC. Word B: 0xB123.
  - cs_n low 128 cycles per word; gap of 4 cycles.
  - ldac_n low for 4 cycles; ready high 268 cycles after handshake.
- OUT_WIDTH = 8, x = 0xFF, y = 0x01 -> words 0x3FF0 and 0xB010.
- valid held high with pairs (0x000, 0xFFF) then (0xFFF, 0x000):
  - Words are 0x3000 and 0xBFFF, then 0x3FFF and 0xB000.
  - ready is high one cycle between pairs; inputs changed while busy are not sampled.
- Reset asserted during bit 5 of word B -> cs_n = 1 and sclk = 0 immediately; no ldac_n pulse; a next transfer completes normally.
- D = 1, x = 0x555, y = 0xAAA -> sclk toggles every cycle; words 0x3555 and 0xBAAA; total transfer 67 cycles.
